// File: rtl/cmd_pkg.sv
// cmd_pkg: command/status codes, dispatcher states and a frame packing helper.
package cmd_pkg;
    localparam logic [7:0] CMD_W  = 8'h77;
    localparam logic [7:0] CMD_R  = 8'h72;
    localparam logic [7:0] CMD_S  = 8'h73;
    localparam logic [7:0] CMD_C  = 8'h63;
    localparam logic [7:0] CMD_P  = 8'h70;
    localparam logic [7:0] STAT_K = 8'h6B;
    localparam logic [7:0] STAT_E = 8'h65;
    localparam logic [7:0] STAT_T = 8'h74;
    typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_R, ISSUE_RMW, RESP} state_t;
    function automatic logic [47:0] pack_frame(input logic [7:0] hd, input logic [7:0] addr,
                                               input logic [31:0] value);
        return {hd, addr, value};
    endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector.
module rise_detect (
    input  logic clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);
    logic prev;
    always_ff @(posedge clk) prev <= i_reset ? 1'b0 : i_sig;
    assign o_rise = i_sig & ~prev;
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: decodes {cmd, addr, value} frames into register-bus strobes
// and returns one {status, addr, value} response per accepted command.
module cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int VALUE_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  i_reset,
    input  logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0] i_data,
    input  logic                                  i_dv,
    output logic                                  o_w_en,
    output logic                                  o_r_en,
    output logic [WORD_WIDTH-1:0]                 o_addr,
    output logic [VALUE_WORDS*WORD_WIDTH-1:0]     o_value,
    input  logic [VALUE_WORDS*WORD_WIDTH-1:0]     i_r_data,
    input  logic                                  i_r_valid,
    output logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0] o_resp_data,
    output logic                                  o_resp_valid,
    input  logic                                  i_resp_ready,
    output logic                                  o_busy,
    output logic                                  o_drop,
    output logic [DROP_CNT_WIDTH-1:0]             o_drop_count
);
    localparam int VW = VALUE_WORDS * WORD_WIDTH;
    localparam int FW = VW + 2 * WORD_WIDTH;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WORD_WIDTH-1:0] C_W = WORD_WIDTH'(CMD_W);
    localparam logic [WORD_WIDTH-1:0] C_R = WORD_WIDTH'(CMD_R);
    localparam logic [WORD_WIDTH-1:0] C_S = WORD_WIDTH'(CMD_S);
    localparam logic [WORD_WIDTH-1:0] C_C = WORD_WIDTH'(CMD_C);
    localparam logic [WORD_WIDTH-1:0] C_P = WORD_WIDTH'(CMD_P);
    localparam logic [WORD_WIDTH-1:0] S_K = WORD_WIDTH'(STAT_K);
    localparam logic [WORD_WIDTH-1:0] S_E = WORD_WIDTH'(STAT_E);
    localparam logic [WORD_WIDTH-1:0] S_T = WORD_WIDTH'(STAT_T);

    state_t state, state_n;
    logic rise, reading, rd_hit, rd_timeout, known, busy_rise;
    logic [WORD_WIDTH-1:0] cmd, f_cmd, f_addr;
    logic [VW-1:0] val, f_val, rd_val;
    logic [CW-1:0] cnt;

    rise_detect u_rise (.clk(clk), .i_reset(i_reset), .i_sig(i_dv), .o_rise(rise));

    assign f_cmd  = i_data[FW-1 -: WORD_WIDTH];
    assign f_addr = i_data[VW +: WORD_WIDTH];
    assign f_val  = i_data[VW-1:0];
    assign known  = f_cmd == C_W || f_cmd == C_R || f_cmd == C_S || f_cmd == C_C || f_cmd == C_P;
    assign reading    = state == ISSUE_R || state == WAIT_R;
    assign rd_hit     = reading && i_r_valid;
    assign rd_timeout = reading && !i_r_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign rd_val     = cmd == C_S ? i_r_data | val : cmd == C_C ? i_r_data & ~val : i_r_data;
    assign busy_rise  = rise && state != IDLE;

    assign o_w_en       = state == ISSUE_W || state == ISSUE_RMW;
    assign o_r_en       = state == ISSUE_R;
    assign o_resp_valid = state == RESP;
    assign o_busy       = state != IDLE;

    always_ff @(posedge clk) state <= i_reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:              if (rise) state_n = f_cmd == C_W ? ISSUE_W :
                                   (f_cmd == C_R || f_cmd == C_S || f_cmd == C_C) ? ISSUE_R : RESP;
            ISSUE_W, ISSUE_RMW: state_n = RESP;
            ISSUE_R, WAIT_R:   state_n = rd_hit ? (cmd == C_R ? RESP : ISSUE_RMW) :
                                   rd_timeout ? RESP : WAIT_R;
            RESP:              if (i_resp_ready) state_n = IDLE;
            default:           state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            cmd          <= '0;
            val          <= '0;
            cnt          <= '0;
            o_addr       <= '0;
            o_value      <= '0;
            o_resp_data  <= '0;
            o_drop       <= 1'b0;
            o_drop_count <= '0;
        end else begin
            o_drop <= busy_rise;
            if (busy_rise && !(&o_drop_count)) o_drop_count <= o_drop_count + 1'b1;
            if (state == IDLE && rise) begin
                cmd         <= f_cmd;
                val         <= f_val;
                cnt         <= '0;
                o_addr      <= f_addr;
                o_value     <= f_val;
                o_resp_data <= {known ? S_K : S_E, f_addr, f_val};
            end
            if (reading && !i_r_valid) cnt <= cnt + 1'b1;
            // read data is registered on the sampling edge; RMW result doubles as write data
            if (rd_hit) begin
                if (cmd != C_R) o_value <= rd_val;
                o_resp_data <= {S_K, o_addr, rd_val};
            end
            if (rd_timeout) o_resp_data <= {S_T, o_addr, VW'(0)};
        end
    end
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: scoreboard bench with a register-file responder and a
// behavioural model of command results, strobe counts and drop counting.
module tb_cmd_dispatcher;
    import cmd_pkg::*;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [47:0] i_data = '0;
    logic        i_dv = 1'b0;
    logic        o_w_en, o_r_en, o_resp_valid, o_busy, o_drop;
    logic [7:0]  o_addr, o_drop_count;
    logic [31:0] o_value;
    logic [31:0] i_r_data = '0;
    logic        i_r_valid = 1'b0;
    logic [47:0] o_resp_data;
    logic        i_resp_ready = 1'b0;

    cmd_dispatcher #(.WORD_WIDTH(8), .VALUE_WORDS(4), .TIMEOUT_CYCLES(TO), .DROP_CNT_WIDTH(8)) dut (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_w_en(o_w_en), .o_r_en(o_r_en), .o_addr(o_addr), .o_value(o_value),
        .i_r_data(i_r_data), .i_r_valid(i_r_valid),
        .o_resp_data(o_resp_data), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_busy(o_busy), .o_drop(o_drop), .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [47:0] exp_q[$];
    logic [39:0] wr_q[$];
    logic [31:0] regs[256], ref_regs[256];
    int exp_w = 0, exp_r = 0, w_seen = 0, r_seen = 0;
    int drops_exp = 0, drop_seen = 0;
    int cur_lat = 0, cd = -1, rmode = 0;
    bit late = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // register file: lat cycles after o_r_en (negative = never answers)
    always @(negedge clk) begin
        i_r_valid = 1'b0;
        i_r_data  = $urandom;
        if (o_w_en) regs[o_addr] = o_value;
        if (i_reset) cd = -1;
        else if (o_r_en) cd = cur_lat;
        else if (cd > 0) cd--;
        if (cd == 0 || late) begin
            i_r_valid = 1'b1;
            i_r_data  = regs[o_addr];
            cd = -1;
            late = 1'b0;
        end
    end

    always begin
        @(posedge clk);
        #1 i_resp_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom % 3 != 0) : 1'b0;
    end

    // monitor: responses, write strobes, read strobes, drop pulses
    always @(negedge clk) begin
        if (o_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL resp_unexpected: got %h, expected no response", o_resp_data);
            end else begin
                check("resp", o_resp_data, exp_q[0]);
                if (i_resp_ready) void'(exp_q.pop_front());
            end
        end
        if (o_w_en) begin
            w_seen++;
            if (wr_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL write_unexpected: got %h, expected no write", {o_addr, o_value});
            end else check("write", {o_addr, o_value}, wr_q.pop_front());
        end
        if (o_r_en) r_seen++;
        if (o_drop) drop_seen++;
    end

    task automatic issue(input logic [7:0] c, input logic [7:0] a, input logic [31:0] v, input int l);
        logic [31:0] nv;
        nv = c == CMD_S ? (ref_regs[a] | v) : (ref_regs[a] & ~v);
        case (c)
            CMD_W: begin exp_q.push_back(pack_frame(STAT_K, a, v)); ref_regs[a] = v; wr_q.push_back({a, v}); exp_w++; end
            CMD_R: begin exp_r++; exp_q.push_back(l < 0 ? pack_frame(STAT_T, a, 0) : pack_frame(STAT_K, a, ref_regs[a])); end
            CMD_S, CMD_C: begin
                exp_r++;
                if (l < 0) exp_q.push_back(pack_frame(STAT_T, a, 0));
                else begin
                    ref_regs[a] = nv;
                    wr_q.push_back({a, nv});
                    exp_w++;
                    exp_q.push_back(pack_frame(STAT_K, a, nv));
                end
            end
            CMD_P:   exp_q.push_back(pack_frame(STAT_K, a, v));
            default: exp_q.push_back(pack_frame(STAT_E, a, v));
        endcase
        cur_lat = l;
        @(negedge clk); i_data = pack_frame(c, a, v); i_dv = 1'b1;
        @(negedge clk); i_dv = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while ((o_busy || o_resp_valid) && n < 300);
        check({tag, "_done"}, 64'(n < 300), 1);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_wcount"}, w_seen, exp_w);
        check({tag, "_rcount"}, r_seen, exp_r);
    endtask

    task automatic run(input string tag, input logic [7:0] c, input logic [7:0] a,
                       input logic [31:0] v, input int l);
        issue(c, a, v, l);
        finish_cmd(tag);
    endtask

    task automatic drop_pulse();
        @(negedge clk); i_data = {$urandom, 16'h0}; i_dv = 1'b1; drops_exp++;
        @(negedge clk); i_dv = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cmds[6];
        cmds = '{CMD_W, CMD_R, CMD_S, CMD_C, CMD_P, 8'h41};
        for (int i = 0; i < 256; i++) begin regs[i] = $urandom; ref_regs[i] = regs[i]; end
        repeat (3) @(negedge clk);
        check("rst_ctrl", {o_w_en, o_r_en, o_busy, o_resp_valid, o_drop, o_drop_count, o_addr}, 0);
        check("rst_value", o_value, 0);
        check("rst_resp", o_resp_data, 0);
        i_reset = 1'b0;
        rmode = 0;
        run("write", CMD_W, 8'h05, 32'hDEADBEEF, 0);
        run("w_pre_read", CMD_W, 8'h02, 32'h12345678, 0);
        run("read", CMD_R, 8'h02, 0, 3);
        run("w_pre_set", CMD_W, 8'h01, 32'h0000000F, 0);
        run("set", CMD_S, 8'h01, 32'h000000F0, 2);
        run("clear", CMD_C, 8'h01, 32'h0000000F, 0);
        run("timeout", CMD_R, 8'h03, 0, -1);
        run("rmw_timeout", CMD_S, 8'h01, 32'hFF00_0000, -1);
        late = 1'b1;
        repeat (3) @(negedge clk);
        check("late_ignored", {o_busy, o_resp_valid, o_w_en, o_r_en}, 0);
        rmode = 2;
        issue(8'h41, 8'h09, 32'hCAFEF00D, 0);
        repeat (10) @(negedge clk);
        check("hold_valid", o_resp_valid, 1);
        rmode = 0;
        finish_cmd("unknown");
        issue(CMD_R, 8'h02, 0, 5);
        @(negedge clk);
        drop_pulse();
        finish_cmd("drop_read");
        check("drop_count_1", o_drop_count, 1);
        check("drop_pulses_1", drop_seen, drops_exp);
        rmode = 2;
        issue(CMD_P, 8'h0A, 32'h0000_1234, 0);
        repeat (300) drop_pulse();
        @(negedge clk);
        check("drop_count_sat", o_drop_count, drops_exp > 255 ? 255 : drops_exp);
        check("drop_pulses_300", drop_seen, drops_exp);
        rmode = 0;
        finish_cmd("ping_drops");
        issue(CMD_R, 8'h04, 0, -1);
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        exp_q.delete(); wr_q.delete();
        exp_w = 0; exp_r = 0; w_seen = 0; r_seen = 0; drops_exp = 0; drop_seen = 0;
        @(negedge clk);
        check("midrst_ctrl", {o_w_en, o_r_en, o_busy, o_resp_valid, o_drop, o_drop_count, o_addr}, 0);
        check("midrst_value", o_value, 0);
        check("midrst_resp", o_resp_data, 0);
        i_reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rmode = $urandom % 2;
            run("random", cmds[$urandom % 6], 8'($urandom % 8), $urandom,
                ($urandom % 8 == 0) ? -1 : int'($urandom_range(0, 5)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
